// File: rtl/bd_pkg.sv
// Shared types and constants for the BPSK transmit path: FSM states, frame
// lengths, DAC idle level and the 8-phase carrier table.
package bd_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  localparam int SYNC_BITS  = 8;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = SYNC_BITS + DATA_BITS + 1;

  localparam logic [7:0] DAC_IDLE = 8'd128;

  localparam logic [7:0] CARRIER_TBL [8] = '{
    8'd128, 8'd218, 8'd255, 8'd218, 8'd128, 8'd37, 8'd0, 8'd37
  };

  // A zero bit is the carrier mirrored about mid-scale (255 - x), so bit 0
  // starts at 127 rather than 128.
  function automatic logic [7:0] carrier_sample(input logic bit_val, input logic [2:0] idx);
    return bit_val ? CARRIER_TBL[idx] : 8'd255 - CARRIER_TBL[idx];
  endfunction

endpackage

// File: rtl/tx_modulator_if.sv
// Host-side byte handshake plus DAC/status outputs of the transmit modulator.
interface tx_modulator_if;
  logic [7:0] DATA_IN;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] DAC;
  logic       busy;
  logic       bitsinc_tx;

  modport master (output DATA_IN, data_valid,
                  input  data_ready, DAC, busy, bitsinc_tx);
  modport slave  (input  DATA_IN, data_valid,
                  output data_ready, DAC, busy, bitsinc_tx);
endinterface

// File: rtl/bpsk_mod.sv
// Registered BPSK sample generator: carrier table lookup for the current bit
// and phase, mid-scale when disabled.
module bpsk_mod
  import bd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_val,
  input  logic [2:0] phase,
  input  logic       en,
  output logic [7:0] sample
);

  always_ff @(posedge clk) begin
    if (rst)
      sample <= DAC_IDLE;
    else if (en)
      sample <= carrier_sample(bit_val, phase);
    else
      sample <= DAC_IDLE;
  end

endmodule

// File: rtl/tx_modulator.sv
// Byte framer (sync word, payload, even parity) driving a BPSK modulator that
// emits one offset-binary DAC sample per clock.
module tx_modulator
  import bd_pkg::*;
#(
  parameter int         SAMPLES_PER_BIT = 16,
  parameter logic [7:0] SYNC_WORD       = 8'h7E
)(
  input logic           G_CLK_TX,
  input logic           reset,
  tx_modulator_if.slave bus
);

  localparam int             CNT_W    = $clog2(SAMPLES_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sample_cnt, sample_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt, bit_last;
  logic [7:0]       payload, payload_nxt;
  logic             bit_nxt;
  logic             bitsinc;
  logic [7:0]       dac;

  // Next-state values drive the modulator directly so the first SYNC sample
  // appears on the same edge that accepts the byte.
  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt;
    bit_cnt_nxt    = bit_cnt;
    payload_nxt    = payload;
    bit_last       = 3'd0;
    case (state)
      SYNC:    bit_last = 3'(SYNC_BITS - 1);
      DATA:    bit_last = 3'(DATA_BITS - 1);
      default: bit_last = 3'd0;
    endcase

    if (state == IDLE) begin
      if (bus.data_valid) begin
        state_nxt      = SYNC;
        sample_cnt_nxt = '0;
        bit_cnt_nxt    = '0;
        payload_nxt    = bus.DATA_IN;
      end
    end else if (sample_cnt == CNT_LAST) begin
      sample_cnt_nxt = '0;
      if (bit_cnt == bit_last) begin
        bit_cnt_nxt = '0;
        case (state)
          SYNC:    state_nxt = DATA;
          DATA:    state_nxt = PARITY;
          default: state_nxt = IDLE;
        endcase
      end else begin
        bit_cnt_nxt = bit_cnt + 3'd1;
      end
    end else begin
      sample_cnt_nxt = sample_cnt + CNT_W'(1);
    end

    case (state_nxt)
      SYNC:    bit_nxt = SYNC_WORD[3'd7 - bit_cnt_nxt];
      DATA:    bit_nxt = payload_nxt[3'd7 - bit_cnt_nxt];
      PARITY:  bit_nxt = ^payload_nxt;
      default: bit_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge G_CLK_TX) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      bitsinc    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= sample_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      bitsinc    <= (state_nxt != IDLE) && (sample_cnt_nxt == '0);
    end
  end

  always_ff @(posedge G_CLK_TX) begin
    payload <= payload_nxt;
  end

  bpsk_mod u_mod (
    .clk     (G_CLK_TX),
    .rst     (reset),
    .bit_val (bit_nxt),
    .phase   (sample_cnt_nxt[2:0]),
    .en      (state_nxt != IDLE),
    .sample  (dac)
  );

  assign bus.data_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.bitsinc_tx = bitsinc;
  assign bus.DAC        = dac;

endmodule

// File: tb/tb_tx_modulator.sv
// Bench for tx_modulator: frames driven with random bytes and checked sample
// by sample against a frame/carrier reference model.
module tb_tx_modulator;

  localparam int         SPB     = 16;
  localparam logic [7:0] SYNC    = 8'h7E;
  localparam int         FRAME_N = 17 * SPB;

  logic clk = 1'b0;
  logic reset;
  tx_modulator_if bus ();

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] dac_log [$];
  int         busy_cnt;

  always #5 clk = ~clk;

  tx_modulator #(.SAMPLES_PER_BIT(SPB), .SYNC_WORD(SYNC)) dut (
    .G_CLK_TX (clk),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected DAC sample at offset i of the frame carrying byte b.
  function automatic logic [7:0] model(input logic [7:0] b, input int i);
    logic [16:0] bits;
    int          tbl [8];
    int          s;
    bits = {SYNC, b, ^b};
    tbl  = '{128, 218, 255, 218, 128, 37, 0, 37};
    s    = tbl[(i % SPB) % 8];
    return bits[16 - i / SPB] ? 8'(s) : 8'(255 - s);
  endfunction

  // Offers b from an idle point and checks the frame; stop_at >= 0 returns
  // before checking sample stop_at (used to interrupt a frame).
  task automatic run_frame(input logic [7:0] b, input bit keep_valid, input int stop_at);
    logic [7:0] exp;
    dac_log.delete();
    busy_cnt = 0;
    bus.DATA_IN    = b;
    bus.data_valid = 1'b1;
    vectors++;
    if (bus.data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept byte=%02h got=%b want=1", b, bus.data_ready);
    end
    tick;
    if (!keep_valid) bus.data_valid = 1'b0;
    for (int j = 0; j < FRAME_N; j++) begin
      if (stop_at >= 0 && j == stop_at) return;
      exp = model(b, j);
      dac_log.push_back(bus.DAC);
      if (bus.busy === 1'b1) busy_cnt++;
      vectors++;
      if ({bus.DAC, bus.busy, bus.data_ready, bus.bitsinc_tx} !==
          {exp, 1'b1, 1'b0, (j % SPB) == 0}) begin
        miscompares++;
        $display("FAIL frame_sample byte=%02h idx=%0d got dac=%0d busy=%b rdy=%b sync=%b want dac=%0d busy=1 rdy=0 sync=%b",
                 b, j, bus.DAC, bus.busy, bus.data_ready, bus.bitsinc_tx, exp, (j % SPB) == 0);
      end
      bus.DATA_IN = 8'($urandom);
      tick;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    vectors++;
    if ({bus.DAC, bus.busy, bus.data_ready, bus.bitsinc_tx} !== {8'd128, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL frame_end byte=%02h got dac=%0d busy=%b rdy=%b sync=%b want dac=128 busy=0 rdy=1 sync=0",
               b, bus.DAC, bus.busy, bus.data_ready, bus.bitsinc_tx);
    end
  endtask

  task automatic test_reset;
    reset          = 1'b1;
    bus.data_valid = 1'b1;
    bus.DATA_IN    = 8'hA5;
    tick;
    tick;
    reset          = 1'b0;
    bus.data_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      vectors++;
      if ({bus.DAC, bus.busy, bus.data_ready, bus.bitsinc_tx} !== {8'd128, 1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL idle_after_reset cyc=%0d got dac=%0d busy=%b rdy=%b sync=%b want 128/0/1/0",
                 i, bus.DAC, bus.busy, bus.data_ready, bus.bitsinc_tx);
      end
      tick;
    end
  endtask

  task automatic test_zero_byte;
    logic [7:0] head0 [8];
    logic [7:0] head1 [8];
    head0 = '{127, 37, 0, 37, 127, 218, 255, 218};
    head1 = '{128, 218, 255, 218, 128, 37, 0, 37};
    run_frame(8'h00, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dac_log[i] !== head0[i] || dac_log[16 + i] !== head1[i]) begin
        miscompares++;
        $display("FAIL zero_byte_head i=%0d got %0d/%0d want %0d/%0d",
                 i, dac_log[i], dac_log[16 + i], head0[i], head1[i]);
      end
    end
    vectors++;
    if (busy_cnt != FRAME_N) begin
      miscompares++;
      $display("FAIL busy_length got=%0d want=%0d", busy_cnt, FRAME_N);
    end
    tick;
  endtask

  task automatic test_parity;
    logic [7:0] one_tbl [8];
    one_tbl = '{128, 218, 255, 218, 128, 37, 0, 37};
    run_frame(8'h01, 1'b0, -1);
    for (int i = 0; i < SPB; i++) begin
      vectors++;
      if (dac_log[FRAME_N - SPB + i] !== one_tbl[i % 8]) begin
        miscompares++;
        $display("FAIL parity_01 i=%0d got=%0d want=%0d", i, dac_log[FRAME_N - SPB + i], one_tbl[i % 8]);
      end
    end
    tick;
    run_frame(8'h03, 1'b0, -1);
    for (int i = 0; i < SPB; i++) begin
      vectors++;
      if (dac_log[FRAME_N - SPB + i] !== 8'(255 - int'(one_tbl[i % 8]))) begin
        miscompares++;
        $display("FAIL parity_03 i=%0d got=%0d want=%0d", i, dac_log[FRAME_N - SPB + i],
                 255 - int'(one_tbl[i % 8]));
      end
    end
    tick;
  endtask

  task automatic test_random_bytes;
    for (int n = 0; n < 4; n++) begin
      run_frame(8'($urandom), 1'b0, -1);
      repeat ($urandom_range(1, 4)) tick;
    end
  endtask

  // Valid held high throughout: each frame must follow a single idle cycle.
  task automatic test_back_to_back;
    logic [7:0] bytes [4];
    bytes = '{8'hA5, 8'h5A, 8'hFF, 8'($urandom)};
    for (int n = 0; n < 4; n++) run_frame(bytes[n], 1'b1, -1);
    bus.data_valid = 1'b0;
    tick;
    vectors++;
    if ({bus.DAC, bus.busy, bus.data_ready} !== {8'd128, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_drain got dac=%0d busy=%b rdy=%b want 128/0/1", bus.DAC, bus.busy, bus.data_ready);
    end
  endtask

  task automatic test_mid_reset;
    run_frame(8'($urandom), 1'b0, 10 * SPB);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    vectors++;
    if ({bus.DAC, bus.busy, bus.data_ready, bus.bitsinc_tx} !== {8'd128, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset got dac=%0d busy=%b rdy=%b sync=%b want 128/0/1/0",
               bus.DAC, bus.busy, bus.data_ready, bus.bitsinc_tx);
    end
    tick;
    vectors++;
    if ({bus.DAC, bus.busy} !== {8'd128, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset_no_tail got dac=%0d busy=%b want 128/0", bus.DAC, bus.busy);
    end
    run_frame(8'($urandom), 1'b0, -1);
    tick;
  endtask

  initial begin
    reset          = 1'b1;
    bus.data_valid = 1'b0;
    bus.DATA_IN    = 8'h00;
    test_reset;
    test_zero_byte;
    test_parity;
    test_random_bytes;
    test_back_to_back;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
